// File: rtl/dmem_io_bridge.sv
// -----------------------------------------------------------------------------
// dmem_io_bridge
//   Data-side memory system for the single-cycle CPU. Decodes the ALU byte
//   address into a word RAM and a small MMIO block (LED register, synchronised
//   switches, compare timer with sticky interrupt flag). Load data is returned
//   combinationally in the same cycle; stores commit on the next rising edge.
//
//   MMIO map (word aligned, addr[1:0] ignored):
//     0xFFFF_0000 LED   RW
//     0xFFFF_0004 SW    RO  (two-flop synchronised sw_in)
//     0xFFFF_0008 TCNT  RW
//     0xFFFF_000C TCMP  RW
//     0xFFFF_0010 TCTL  bit0 EN, bit1 RELOAD (RW); bit8 FLAG (read, W1C)
//   Anything outside RAM and this map reads 0 and ignores writes.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous active-low reset
//   addr       byte address from the CPU ALU
//   wdata      store data
//   mem_write  store strobe, committed at the next rising edge
//   rdata      load data, combinational from addr and current state
//   sw_in      asynchronous board switches
//   led_out    LED register contents
//   timer_irq  timer status flag (sticky until W1C or reset)
// -----------------------------------------------------------------------------
module dmem_io_bridge #(
    parameter int DMEM_WORDS = 1024,
    parameter int LED_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic             mem_write,
    output logic [31:0]      rdata,
    input  logic [LED_W-1:0] sw_in,
    output logic [LED_W-1:0] led_out,
    output logic             timer_irq
);

    localparam int AW = $clog2(DMEM_WORDS);

    // Word addresses (byte address >> 2) of the MMIO registers.
    localparam logic [29:0] WA_LED  = 30'h3FFF_C000;
    localparam logic [29:0] WA_SW   = 30'h3FFF_C001;
    localparam logic [29:0] WA_TCNT = 30'h3FFF_C002;
    localparam logic [29:0] WA_TCMP = 30'h3FFF_C003;
    localparam logic [29:0] WA_TCTL = 30'h3FFF_C004;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_LED,
        SEL_SW,
        SEL_TCNT,
        SEL_TCMP,
        SEL_TCTL
    } sel_e;

    sel_e           sel;
    logic [29:0]    word_addr;
    logic [AW-1:0]  ram_idx;
    logic           unused_addr_lsb;

    logic [31:0]      ram [DMEM_WORDS];
    logic [LED_W-1:0] led;
    logic [LED_W-1:0] sw_meta;
    logic [LED_W-1:0] sw_sync;

    logic [31:0] tcnt, tcnt_nxt;
    logic [31:0] tcmp;
    logic        en, en_nxt;
    logic        reload, reload_nxt;
    logic        flag, flag_nxt;
    logic        match;

    logic wr_ram, wr_led, wr_tcnt, wr_tcmp, wr_tctl;

    assign word_addr       = addr[31:2];
    assign ram_idx         = addr[AW+1:2];
    // Word access only: the byte offset plays no part in decode.
    assign unused_addr_lsb = ^addr[1:0];

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        sel = SEL_NONE;
        if (addr[31:AW+2] == '0) begin
            sel = SEL_RAM;
        end else begin
            case (word_addr)
                WA_LED:  sel = SEL_LED;
                WA_SW:   sel = SEL_SW;
                WA_TCNT: sel = SEL_TCNT;
                WA_TCMP: sel = SEL_TCMP;
                WA_TCTL: sel = SEL_TCTL;
                default: sel = SEL_NONE;
            endcase
        end
    end

    assign wr_ram  = mem_write && (sel == SEL_RAM);
    assign wr_led  = mem_write && (sel == SEL_LED);
    assign wr_tcnt = mem_write && (sel == SEL_TCNT);
    assign wr_tcmp = mem_write && (sel == SEL_TCMP);
    assign wr_tctl = mem_write && (sel == SEL_TCTL);

    // ------------------------------------------------------------------
    // Data RAM: asynchronous read, synchronous write
    // ------------------------------------------------------------------
    // NOTE: the RAM array has no reset so it can map onto distributed/block
    // memory; software must initialise any words it relies on.
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            // NOTE: non-blocking assignment for all clocked state so every
            // register samples pre-edge values regardless of block order.
            ram[ram_idx] <= wdata;
        end
    end

    // ------------------------------------------------------------------
    // LED register and switch synchroniser
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            led     <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
            if (wr_led) begin
                led <= wdata[LED_W-1:0];
            end
        end
    end

    assign led_out = led;

    // ------------------------------------------------------------------
    // Compare timer next-state
    //   A CPU write to TCNT beats both increment and match. A match sets
    //   FLAG and either reloads to 0 or stops the timer holding TCNT.
    //   A TCTL write's EN value overrides the match auto-stop, and a match
    //   set beats a simultaneous W1C.
    // ------------------------------------------------------------------
    always_comb begin
        tcnt_nxt   = tcnt;
        en_nxt     = en;
        reload_nxt = reload;
        flag_nxt   = flag;
        match      = 1'b0;

        if (wr_tcnt) begin
            tcnt_nxt = wdata;
        end else if (en) begin
            if (tcnt == tcmp) begin
                match = 1'b1;
                if (reload) begin
                    tcnt_nxt = '0;
                end else begin
                    en_nxt = 1'b0;
                end
            end else begin
                tcnt_nxt = tcnt + 32'd1;
            end
        end

        if (wr_tctl) begin
            en_nxt     = wdata[0];
            reload_nxt = wdata[1];
            if (wdata[8]) begin
                flag_nxt = 1'b0;
            end
        end

        if (match) begin
            flag_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tcnt   <= '0;
            tcmp   <= 32'hFFFF_FFFF;
            en     <= 1'b0;
            reload <= 1'b0;
            flag   <= 1'b0;
        end else begin
            tcnt   <= tcnt_nxt;
            en     <= en_nxt;
            reload <= reload_nxt;
            flag   <= flag_nxt;
            if (wr_tcmp) begin
                tcmp <= wdata;
            end
        end
    end

    assign timer_irq = flag;

    // ------------------------------------------------------------------
    // Load data mux
    // ------------------------------------------------------------------
    always_comb begin
        rdata = '0;
        case (sel)
            SEL_RAM:  rdata = ram[ram_idx];
            SEL_LED:  rdata[LED_W-1:0] = led;
            SEL_SW:   rdata[LED_W-1:0] = sw_sync;
            SEL_TCNT: rdata = tcnt;
            SEL_TCMP: rdata = tcmp;
            SEL_TCTL: begin
                rdata[0] = en;
                rdata[1] = reload;
                rdata[8] = flag;
            end
            default:  rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_dmem_io_bridge.sv
// -----------------------------------------------------------------------------
// tb_dmem_io_bridge
//   Self-checking bench for dmem_io_bridge. Every bus operation takes exactly
//   one clock: inputs are driven 1 time unit after the rising edge and load
//   data is sampled on the falling edge. Expected load values are queued when
//   the read is issued and popped when rdata is sampled. Pin-level outputs
//   (led_out, timer_irq) are checked inline by each scenario task.
// -----------------------------------------------------------------------------
module tb_dmem_io_bridge;

    localparam logic [31:0] A_LED  = 32'hFFFF_0000;
    localparam logic [31:0] A_SW   = 32'hFFFF_0004;
    localparam logic [31:0] A_TCNT = 32'hFFFF_0008;
    localparam logic [31:0] A_TCMP = 32'hFFFF_000C;
    localparam logic [31:0] A_TCTL = 32'hFFFF_0010;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_write = 1'b0;
    logic [31:0] rdata;
    logic [15:0] sw_in = '0;
    logic [15:0] led_out;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    dmem_io_bridge #(
        .DMEM_WORDS (1024),
        .LED_W      (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wdata     (wdata),
        .mem_write (mem_write),
        .rdata     (rdata),
        .sw_in     (sw_in),
        .led_out   (led_out),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // One bus cycle; optionally queues an expected load value and compares
    // it against rdata on the falling edge.
    task automatic bus_cycle(input logic [31:0] a, input logic [31:0] d,
                             input logic we, input bit chk,
                             input logic [31:0] exp, input string tag);
        logic [31:0] e;
        string       t;
        addr      = a;
        wdata     = d;
        mem_write = we;
        if (chk) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
        @(negedge clk);
        if (chk) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (rdata !== e) begin
                errors++;
                $display("FAIL %s: rdata=%h expected=%h", t, rdata, e);
            end
        end
        @(posedge clk);
        #1;
        mem_write = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus_cycle(a, d, 1'b1, 1'b0, 32'h0, "");
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        bus_cycle(a, 32'h0, 1'b0, 1'b1, exp, tag);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (led_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_led: led_out=%h expected=%h", led_out, 16'h0000);
        end
        checks++;
        if (timer_irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: timer_irq=%b expected=0", timer_irq);
        end
        rd(A_TCMP, 32'hFFFF_FFFF, "reset_tcmp");
        rd(A_TCNT, 32'h0, "reset_tcnt");
        rd(A_TCTL, 32'h0, "reset_tctl");
        rst = 1'b1;
        rd(A_SW, 32'h0, "reset_sw");
    endtask

    task automatic test_ram();
        wr(32'h0000_0014, 32'h1234_5678);
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_load_10");
        rd(32'h0000_0013, 32'hDEAD_BEEF, "ram_load_13");
        rd(32'h0000_0014, 32'h1234_5678, "ram_neighbour_14");
        wr(32'h0000_0FFC, 32'hA5A5_0FFC);
        rd(32'h0000_0FFC, 32'hA5A5_0FFC, "ram_top_word");
    endtask

    task automatic test_back_to_back();
        wr(32'h0000_0020, 32'h1111_1111);
        wr(32'h0000_0024, 32'h2222_2222);
        rd(32'h0000_0020, 32'h1111_1111, "b2b_load_20");
        wr(32'h0000_0020, 32'h3333_3333);
        rd(32'h0000_0020, 32'h3333_3333, "b2b_reload_20");
        rd(32'h0000_0024, 32'h2222_2222, "b2b_load_24");
    endtask

    task automatic test_mmio();
        wr(A_LED, 32'h0000_00A5);
        checks++;
        if (led_out !== 16'h00A5) begin
            errors++;
            $display("FAIL led_out: led_out=%h expected=%h", led_out, 16'h00A5);
        end
        rd(A_LED, 32'h0000_00A5, "led_read");
        rd(32'hFFFF_0002, 32'h0000_00A5, "led_read_byte_offset");

        sw_in = 16'h1234;
        rd(A_SW, 32'h0, "sw_before_edge1");
        rd(A_SW, 32'h0, "sw_before_edge2");
        rd(A_SW, 32'h0000_1234, "sw_after_edge2");
        wr(A_SW, 32'h0000_FFFF);
        rd(A_SW, 32'h0000_1234, "sw_write_ignored");
    endtask

    task automatic test_timer_oneshot();
        wr(A_TCMP, 32'd5);
        wr(A_TCNT, 32'd0);
        wr(A_TCTL, 32'h1);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (timer_irq !== 1'b0) begin
                errors++;
                $display("FAIL oneshot_irq_early: cycle=%0d timer_irq=%b expected=0", i, timer_irq);
            end
            rd(A_TCNT, 32'(i), "oneshot_count");
        end
        checks++;
        if (timer_irq !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_irq: timer_irq=%b expected=1", timer_irq);
        end
        rd(A_TCNT, 32'd5, "oneshot_hold");
        rd(A_TCTL, 32'h0000_0100, "oneshot_tctl");
        rd(A_TCNT, 32'd5, "oneshot_hold2");
    endtask

    task automatic test_reload_w1c();
        wr(A_TCTL, 32'h0000_0100);
        checks++;
        if (timer_irq !== 1'b0) begin
            errors++;
            $display("FAIL w1c_clear: timer_irq=%b expected=0", timer_irq);
        end
        wr(A_TCMP, 32'd3);
        wr(A_TCNT, 32'd0);
        wr(A_TCTL, 32'h3);
        rd(A_TCNT, 32'd0, "reload_cnt0");
        rd(A_TCNT, 32'd1, "reload_cnt1");
        rd(A_TCNT, 32'd2, "reload_cnt2");
        // TCNT==TCMP this cycle: W1C collides with the match.
        bus_cycle(A_TCTL, 32'h0000_0103, 1'b1, 1'b1, 32'h0000_0003, "collide_tctl_pre");
        checks++;
        if (timer_irq !== 1'b1) begin
            errors++;
            $display("FAIL collide_irq: timer_irq=%b expected=1", timer_irq);
        end
        rd(A_TCTL, 32'h0000_0103, "collide_tctl_post");
        wr(A_TCTL, 32'h0000_0100);
        checks++;
        if (timer_irq !== 1'b0) begin
            errors++;
            $display("FAIL later_w1c_irq: timer_irq=%b expected=0", timer_irq);
        end
        rd(A_TCNT, 32'd2, "stopped_cnt");
        rd(A_TCNT, 32'd2, "stopped_cnt_hold");
    endtask

    task automatic test_wrap();
        wr(A_TCMP, 32'd5);
        wr(A_TCNT, 32'hFFFF_FFFF);
        wr(A_TCTL, 32'h1);
        rd(A_TCNT, 32'hFFFF_FFFF, "wrap_max");
        rd(A_TCNT, 32'd0, "wrap_zero");
        rd(A_TCNT, 32'd1, "wrap_one");
        wr(A_TCTL, 32'h0);
        rd(A_TCNT, 32'd3, "wrap_stopped");
    endtask

    task automatic test_unmapped();
        wr(32'h0000_0000, 32'h0BAD_F00D);
        wr(32'h8000_0000, 32'hFFFF_FFFF);
        wr(32'hFFFF_0014, 32'hFFFF_FFFF);
        wr(32'h0000_1000, 32'hFFFF_FFFF);
        rd(32'h8000_0000, 32'h0, "unmapped_8000");
        rd(32'hFFFF_0014, 32'h0, "unmapped_ffff0014");
        rd(32'h0000_1000, 32'h0, "unmapped_past_ram");
        rd(32'h0000_0000, 32'h0BAD_F00D, "unmapped_ram0_intact");
        checks++;
        if (led_out !== 16'h00A5) begin
            errors++;
            $display("FAIL unmapped_led: led_out=%h expected=%h", led_out, 16'h00A5);
        end
        rd(A_TCNT, 32'd3, "unmapped_tcnt");
        rd(A_TCMP, 32'd5, "unmapped_tcmp");
        rd(A_TCTL, 32'h0, "unmapped_tctl");
    endtask

    task automatic test_reset_midrun();
        wr(A_TCMP, 32'd100);
        wr(A_TCNT, 32'd0);
        wr(A_TCTL, 32'h3);
        rd(A_TCNT, 32'd0, "midrun_cnt0");
        rd(A_TCNT, 32'd1, "midrun_cnt1");
        rst = 1'b0;
        @(posedge clk);
        #1;
        rd(A_TCNT, 32'd0, "midrun_rst_tcnt");
        rd(A_TCMP, 32'hFFFF_FFFF, "midrun_rst_tcmp");
        rd(A_SW, 32'h0, "midrun_rst_sw");
        checks++;
        if (led_out !== 16'h0000) begin
            errors++;
            $display("FAIL midrun_rst_led: led_out=%h expected=%h", led_out, 16'h0000);
        end
        rst = 1'b1;
        rd(A_TCNT, 32'd0, "midrun_after_cnt_a");
        rd(A_TCNT, 32'd0, "midrun_after_cnt_b");
        rd(32'h0000_0010, 32'hDEAD_BEEF, "midrun_ram_kept");
        rd(A_SW, 32'h0000_1234, "midrun_sw_resync");
    endtask

    initial begin
        test_reset();
        test_ram();
        test_back_to_back();
        test_mmio();
        test_timer_oneshot();
        test_reload_w1c();
        test_wrap();
        test_unmapped();
        test_reset_midrun();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
